// File: rtl/apb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_bridge_pkg
//  Shared definitions for the AHB-to-APB bridge sequencer.
//  Contents:
//    state_t                    - sequencer states
//    HRESP_OKAY / HRESP_ERROR   - AHB response encodings
//    DEF_WIDTH / DEF_SLAVES / DEF_SEL_LSB - default parameter values
// ----------------------------------------------------------------------------
package apb_bridge_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SLAVES  = 3;
    localparam int DEF_SEL_LSB = 8;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// ----------------------------------------------------------------------------
// apb_addr_decode
//  Combinational slave decode: turns the slave-index field of the address
//  into a one-hot select and a hit flag. Indices >= SLAVES select nothing.
//  Ports:
//    idx  in   IDXW    slave-index field taken from the address
//    sel  out  SLAVES  one-hot select (all zero on a miss)
//    hit  out  1       index addresses an existing slave
// ----------------------------------------------------------------------------
module apb_addr_decode #(
    parameter int SLAVES = 3,
    parameter int IDXW   = 2
) (
    input  logic [IDXW-1:0]   idx,
    output logic [SLAVES-1:0] sel,
    output logic              hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            if (idx == IDXW'(i)) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// apb_xfer_ctrl
//  Bridge sequencer between the AHB slave front-end and the APB master output
//  stage. Takes one decoded AHB transfer at a time, selects the target APB
//  slave and runs the APB SETUP/ACCESS phases. Unmapped slave indices get a
//  two-cycle AHB ERROR response and never touch APB.
//
//  Build option: define APB_PREADY_EN to let Pready stretch the ACCESS phase;
//  without it Pready is ignored and ACCESS is always one cycle.
//
//  Handshake: Valid qualifies Haddr_in/Hwrite_in and is sampled only while
//  the sequencer is idle (Hreadyout=1, Hresp=0); in every other state it is
//  ignored. Hwdata_in is taken in the cycle after a write is accepted.
//  Hreadyout rising back to 1 marks completion (with Hrdata valid on reads);
//  a new Valid in that very cycle is accepted without a bubble.
//
//  Ports:
//    Hclk, Hresetn           clock, asynchronous active-low reset
//    Valid, Haddr_in,
//    Hwrite_in, Hwdata_in    AHB-side transfer request and write data
//    Prdata_in, Pready       APB-side read data and ready
//    Paddr_in, Pwrite_in,
//    Penable_in, Pwdata_in,
//    Pselx_in                APB outputs to the output stage (registered)
//    Hreadyout, Hresp,
//    Hrdata                  AHB response (registered)
//    fsm_state               current sequencer state, for observation
// ----------------------------------------------------------------------------
module apb_xfer_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SLAVES  = DEF_SLAVES,
    parameter int SEL_LSB = DEF_SEL_LSB
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Valid,
    input  logic [WIDTH-1:0]  Haddr_in,
    input  logic              Hwrite_in,
    input  logic [WIDTH-1:0]  Hwdata_in,
    input  logic [WIDTH-1:0]  Prdata_in,
    input  logic              Pready,
    output logic [WIDTH-1:0]  Paddr_in,
    output logic              Pwrite_in,
    output logic              Penable_in,
    output logic [WIDTH-1:0]  Pwdata_in,
    output logic [SLAVES-1:0] Pselx_in,
    output logic              Hreadyout,
    output logic              Hresp,
    output logic [WIDTH-1:0]  Hrdata,
    output state_t            fsm_state
);

    localparam int IDXW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    state_t            state;
    logic [WIDTH-1:0]  addr_q;
    logic [SLAVES-1:0] sel_q;
    logic [SLAVES-1:0] dec_sel;
    logic              dec_hit;
    logic              access_done;

    apb_addr_decode #(
        .SLAVES (SLAVES),
        .IDXW   (IDXW)
    ) u_decode (
        .idx (Haddr_in[SEL_LSB +: IDXW]),
        .sel (dec_sel),
        .hit (dec_hit)
    );

`ifdef APB_PREADY_EN
    assign access_done = Pready;
`else
    logic unused_pready;
    assign unused_pready = Pready;
    assign access_done   = 1'b1;
`endif

    assign fsm_state = state;

    // Outputs are loaded on the transition into a state, so the value of
    // 'state' always names the phase currently visible on the outputs.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            sel_q      <= '0;
            Paddr_in   <= '0;
            Pwrite_in  <= 1'b0;
            Penable_in <= 1'b0;
            Pwdata_in  <= '0;
            Pselx_in   <= '0;
            Hreadyout  <= 1'b1;
            Hresp      <= HRESP_OKAY;
            Hrdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    Hreadyout  <= 1'b1;
                    Hresp      <= HRESP_OKAY;
                    Pselx_in   <= '0;
                    Penable_in <= 1'b0;
                    if (Valid) begin
                        Hreadyout <= 1'b0;
                        if (!dec_hit) begin
                            Hresp <= HRESP_ERROR;
                            state <= ST_ERR1;
                        end else if (Hwrite_in) begin
                            // Write data arrives next cycle; hold the
                            // address phase internally until then.
                            addr_q <= Haddr_in;
                            sel_q  <= dec_sel;
                            state  <= ST_WWAIT;
                        end else begin
                            Paddr_in  <= Haddr_in;
                            Pwrite_in <= 1'b0;
                            Pselx_in  <= dec_sel;
                            state     <= ST_SETUP;
                        end
                    end
                end
                ST_WWAIT: begin
                    Pwdata_in <= Hwdata_in;
                    Paddr_in  <= addr_q;
                    Pwrite_in <= 1'b1;
                    Pselx_in  <= sel_q;
                    state     <= ST_SETUP;
                end
                ST_SETUP: begin
                    Penable_in <= 1'b1;
                    state      <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        Penable_in <= 1'b0;
                        Pselx_in   <= '0;
                        Hreadyout  <= 1'b1;
                        if (!Pwrite_in) begin
                            Hrdata <= Prdata_in;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_ERR1: begin
                    // Second ERROR cycle: ready rises while Hresp stays high.
                    Hreadyout <= 1'b1;
                    state     <= ST_ERR2;
                end
                ST_ERR2: begin
                    Hresp <= HRESP_OKAY;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apb_xfer_ctrl
//  Self-checking bench for apb_xfer_ctrl. A transaction-level reference model
//  turns each AHB request into the expected per-cycle output timeline; the
//  driver plays the request and records what the DUT shows at each negedge.
// ----------------------------------------------------------------------------
module tb_apb_xfer_ctrl;
    import apb_bridge_pkg::*;

    typedef struct packed {
        logic        hready;
        logic        hresp;
        logic [2:0]  pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [31:0] hrdata;
    } obs_t;

    logic        Hclk;
    logic        Hresetn;
    logic        Valid;
    logic [31:0] Haddr_in;
    logic        Hwrite_in;
    logic [31:0] Hwdata_in;
    logic [31:0] Prdata_in;
    logic        Pready;
    logic [31:0] Paddr_in;
    logic        Pwrite_in;
    logic        Penable_in;
    logic [31:0] Pwdata_in;
    logic [2:0]  Pselx_in;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;
    state_t      dut_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: values the P*/Hrdata outputs hold between transfers.
    logic [31:0] m_paddr;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic [31:0] m_hrdata;

    obs_t        exp_tr[$];
    obs_t        obs_q[$];
    logic [31:0] exp_q[$];

    apb_xfer_ctrl #(.WIDTH(32), .SLAVES(3), .SEL_LSB(8)) dut (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .Valid      (Valid),
        .Haddr_in   (Haddr_in),
        .Hwrite_in  (Hwrite_in),
        .Hwdata_in  (Hwdata_in),
        .Prdata_in  (Prdata_in),
        .Pready     (Pready),
        .Paddr_in   (Paddr_in),
        .Pwrite_in  (Pwrite_in),
        .Penable_in (Penable_in),
        .Pwdata_in  (Pwdata_in),
        .Pselx_in   (Pselx_in),
        .Hreadyout  (Hreadyout),
        .Hresp      (Hresp),
        .Hrdata     (Hrdata),
        .fsm_state  (dut_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    function automatic obs_t sample();
        sample = {Hreadyout, Hresp, Pselx_in, Penable_in, Pwrite_in, Paddr_in, Pwdata_in, Hrdata};
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.hready = 1'b1;
        return o;
    endfunction

    function automatic int eff_stalls(input int stalls);
`ifdef APB_PREADY_EN
        return stalls;
`else
        return 0;
`endif
    endfunction

    // ---------------- reference model ----------------
    // Timeline of one transfer accepted at T0; entry k-1 is what cycle Tk shows.
    task automatic model_xfer(input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [31:0] prdata,
                              input int stalls);
        int   idx;
        int   s;
        obs_t o;
        idx = int'(addr[9:8]);
        s   = eff_stalls(stalls);
        exp_tr.delete();
        o = {1'b0, 1'b0, 3'b000, 1'b0, m_pwrite, m_paddr, m_pwdata, m_hrdata};
        if (idx >= 3) begin
            o.hresp = 1'b1;
            exp_tr.push_back(o);
            o.hready = 1'b1;
            exp_tr.push_back(o);
            o.hresp = 1'b0;
            exp_tr.push_back(o);
        end else begin
            if (wr) begin
                exp_tr.push_back(o);
                m_pwdata = wdata;
            end
            m_paddr  = addr;
            m_pwrite = wr;
            o = {1'b0, 1'b0, 3'(1 << idx), 1'b0, m_pwrite, m_paddr, m_pwdata, m_hrdata};
            exp_tr.push_back(o);
            o.penable = 1'b1;
            for (int i = 0; i <= s; i++) exp_tr.push_back(o);
            if (!wr) m_hrdata = prdata;
            o = {1'b1, 1'b0, 3'b000, 1'b0, m_pwrite, m_paddr, m_pwdata, m_hrdata};
            exp_tr.push_back(o);
        end
    endtask

    // ---------------- drivers ----------------
    // Called between a negedge and the next posedge while the DUT is idle;
    // returns at the negedge of the first idle cycle after completion.
    task automatic drive_xfer(input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [31:0] prdata,
                              input int stalls);
        int   len;
        int   acc_k;
        logic hit;
        hit   = (addr[9:8] != 2'd3);
        acc_k = wr ? 3 : 2;
        len   = !hit ? 3 : (wr ? 4 : 3) + eff_stalls(stalls);
        obs_q.delete();
        Valid     = 1'b1;
        Haddr_in  = addr;
        Hwrite_in = wr;
        Prdata_in = prdata;
        Hwdata_in = $urandom;
        Pready    = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(posedge Hclk);
            #1;
            // Junk on Valid/address while busy: the DUT must ignore it.
            Valid     = (k == len) ? 1'b0 : 1'($urandom_range(0, 1));
            Haddr_in  = $urandom;
            Hwrite_in = 1'($urandom_range(0, 1));
            Hwdata_in = (k == 1) ? wdata : $urandom;
            Pready    = (hit && k >= acc_k && k < acc_k + stalls) ? 1'b0 : 1'b1;
            @(negedge Hclk);
            obs_q.push_back(sample());
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] prdata,
                        input int stalls);
        model_xfer(addr, wr, wdata, prdata, stalls);
        drive_xfer(addr, wr, wdata, prdata, stalls);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Hclk);
            #1;
            Valid    = 1'b0;
            Haddr_in = $urandom;
            @(negedge Hclk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Hresetn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Hclk);
            #1;
            Valid     = 1'(i % 2);
            Haddr_in  = $urandom;
            Hwrite_in = 1'($urandom_range(0, 1));
            @(negedge Hclk);
            n_tests++;
            if (sample() !== reset_obs()) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d: got %h expected %h", i, sample(), reset_obs());
            end
        end
        n_tests++;
        if (dut_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dut_state, ST_IDLE);
        end
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
        @(posedge Hclk);
        #1;
        Hresetn = 1'b1;
        Valid   = 1'b0;
        @(negedge Hclk);
    endtask

    task automatic test_read();
        exp_q.push_back(32'hDEAD_BEEF);
        xfer(32'h0000_0100, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
        for (int k = 0; k < exp_tr.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_tr[k]) begin
                n_fail++;
                $display("FAIL read_trace T%0d: got %h expected %h", k + 1, obs_q[k], exp_tr[k]);
            end
        end
        n_tests++;
        if (obs_q[obs_q.size() - 1].hrdata !== exp_q[0]) begin
            n_fail++;
            $display("FAIL read_hrdata: got %h expected %h", obs_q[obs_q.size() - 1].hrdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_write();
        xfer(32'h0000_0200, 1'b1, 32'hA5A5_0F0F, $urandom, 0);
        for (int k = 0; k < exp_tr.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_tr[k]) begin
                n_fail++;
                $display("FAIL write_trace T%0d: got %h expected %h", k + 1, obs_q[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_miss();
        xfer(32'h0000_0300, 1'b0, 32'h0, $urandom, 0);
        for (int k = 0; k < exp_tr.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_tr[k]) begin
                n_fail++;
                $display("FAIL miss_trace T%0d: got %h expected %h", k + 1, obs_q[k], exp_tr[k]);
            end
        end
        xfer(32'h0000_0300, 1'b1, $urandom, $urandom, 0);
        for (int k = 0; k < exp_tr.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_tr[k]) begin
                n_fail++;
                $display("FAIL miss_write_trace T%0d: got %h expected %h", k + 1, obs_q[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_pready_stall();
        xfer(32'h0000_0004, 1'b0, 32'h0, 32'h1234_5678, 3);
        for (int k = 0; k < exp_tr.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_tr[k]) begin
                n_fail++;
                $display("FAIL stall_read_trace T%0d: got %h expected %h", k + 1, obs_q[k], exp_tr[k]);
            end
        end
        xfer(32'h0000_0108, 1'b1, 32'hCAFE_F00D, $urandom, 2);
        for (int k = 0; k < exp_tr.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_tr[k]) begin
                n_fail++;
                $display("FAIL stall_write_trace T%0d: got %h expected %h", k + 1, obs_q[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic        w;
        for (int t = 0; t < 8; t++) begin
            a = {$urandom_range(0, 65535), 6'd0, 2'(t % 4), 8'($urandom)};
            w = 1'(t % 3 == 1);
            xfer(a, w, $urandom, $urandom, 0);
            for (int k = 0; k < exp_tr.size(); k++) begin
                n_tests++;
                if (obs_q[k] !== exp_tr[k]) begin
                    n_fail++;
                    $display("FAIL b2b_trace xfer %0d T%0d: got %h expected %h", t, k + 1, obs_q[k], exp_tr[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] rd;
        logic        w;
        for (int t = 0; t < 40; t++) begin
            a  = $urandom;
            w  = 1'($urandom_range(0, 1));
            rd = $urandom;
            if (!w && a[9:8] != 2'd3) exp_q.push_back(rd);
            xfer(a, w, $urandom, rd, $urandom_range(0, 3));
            for (int k = 0; k < exp_tr.size(); k++) begin
                n_tests++;
                if (obs_q[k] !== exp_tr[k]) begin
                    n_fail++;
                    $display("FAIL rand_trace xfer %0d T%0d: got %h expected %h", t, k + 1, obs_q[k], exp_tr[k]);
                end
            end
            if (exp_q.size() != 0) begin
                n_tests++;
                if (obs_q[obs_q.size() - 1].hrdata !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_hrdata xfer %0d: got %h expected %h", t, obs_q[obs_q.size() - 1].hrdata, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_access();
        Valid     = 1'b1;
        Haddr_in  = 32'h0000_0200;
        Hwrite_in = 1'b0;
        Prdata_in = 32'h5555_AAAA;
        Pready    = 1'b1;
        @(posedge Hclk);
        #1;
        Valid = 1'b0;
        @(posedge Hclk);
        #1;
        Pready = 1'b0;
        @(negedge Hclk);
        n_tests++;
        if (Penable_in !== 1'b1 || Pselx_in !== 3'b100) begin
            n_fail++;
            $display("FAIL midrst_access: got penable %b pselx %b expected penable 1 pselx 100", Penable_in, Pselx_in);
        end
        Hresetn = 1'b0;
        #1;
        n_tests++;
        if (sample() !== reset_obs()) begin
            n_fail++;
            $display("FAIL midrst_immediate: got %h expected %h", sample(), reset_obs());
        end
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
        @(posedge Hclk);
        #1;
        Hresetn = 1'b1;
        Pready  = 1'b1;
        @(negedge Hclk);
        xfer(32'h0000_0110, 1'b0, 32'h0, 32'h0BAD_F00D, 0);
        for (int k = 0; k < exp_tr.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_tr[k]) begin
                n_fail++;
                $display("FAIL midrst_next_read T%0d: got %h expected %h", k + 1, obs_q[k], exp_tr[k]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        Hresetn   = 1'b0;
        Valid     = 1'b0;
        Haddr_in  = '0;
        Hwrite_in = 1'b0;
        Hwdata_in = '0;
        Prdata_in = '0;
        Pready    = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_miss();
        test_pready_stall();
        test_back_to_back();
        idle_cycles(2);
        test_random();
        test_reset_mid_access();
        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
